// File: rtl/game_pkg.sv
// Shared game definitions: direction bit indices, the button-event FSM encoding,
// and the up > down > left > right priority pick used to turn edges into one move.
package game_pkg;

    localparam int DIR_W     = 4;
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [DIR_W-1:0] pick_dir(input logic [DIR_W-1:0] rise);
        logic [DIR_W-1:0] sel;
        sel = '0;
        if (rise[DIR_UP])         sel[DIR_UP]    = 1'b1;
        else if (rise[DIR_DOWN])  sel[DIR_DOWN]  = 1'b1;
        else if (rise[DIR_LEFT])  sel[DIR_LEFT]  = 1'b1;
        else if (rise[DIR_RIGHT]) sel[DIR_RIGHT] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One push-button bit: 2-flop synchronizer followed by a stable-sample counter
// that flips the debounced level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the four board buttons and turns presses into single one-hot move events
// with a valid/ready handshake. Define BUTTON_AUTOREPEAT_EN to re-issue a held move.
module button_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIR_W-1:0] btn_raw,
    input  logic             dir_ready,
    output logic             dir_valid,
    output logic [DIR_W-1:0] dir,
    output logic [DIR_W-1:0] btn_level
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic [DIR_W-1:0] level_w;
    logic [DIR_W-1:0] rise_w;

    for (genvar i = 0; i < DIR_W; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(level_w[i])
        );
    end

    logic [DIR_W-1:0] level_prev_q, level_prev_d;
    state_t           state_q, state_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             valid_q, valid_d;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
    logic [DIR_W-1:0] last_dir_q, last_dir_d;
`endif

    // Edges seen outside IDLE are simply not looked at, so they are dropped rather than queued.
    assign rise_w       = level_w & ~level_prev_q;
    assign level_prev_d = level_w;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        valid_d = valid_q;
`ifdef BUTTON_AUTOREPEAT_EN
        rep_cnt_d  = '0;
        last_dir_d = last_dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (|rise_w) begin
                    dir_d   = pick_dir(rise_w);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && dir_ready) begin
                    valid_d = 1'b0;
                    dir_d   = '0;
                    state_d = RELEASE;
`ifdef BUTTON_AUTOREPEAT_EN
                    last_dir_d = dir_q;
`endif
                end
            end
            RELEASE: begin
`ifdef BUTTON_AUTOREPEAT_EN
                if (level_w == '0) begin
                    state_d = IDLE;
                end else if (level_w == last_dir_q) begin
                    if (rep_cnt_q == REP_LAST) begin
                        dir_d   = last_dir_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
`else
                if (level_w == '0) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                dir_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev_q <= '0;
            state_q      <= IDLE;
            dir_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            level_prev_q <= level_prev_d;
            state_q      <= state_d;
            dir_q        <= dir_d;
            valid_q      <= valid_d;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q  <= '0;
            last_dir_q <= '0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            last_dir_q <= last_dir_d;
        end
    end
`endif

    assign dir_valid = valid_q;
    assign dir       = dir_q;
    assign btn_level = level_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/repeat periods: table of press
// patterns plus hand sequences for stall, reset and auto-repeat behaviour.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int REP = 16;
    localparam int LAT = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       dir_ready;
    logic       dir_valid;
    logic [3:0] dir;
    logic [3:0] btn_level;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .dir_ready(dir_ready),
        .dir_valid(dir_valid),
        .dir      (dir),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] dir;
        int         cyc;
        int         width;   // 0 = do not check how long valid stays high
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] raw;
        int         hold;
        logic [3:0] exp_dir;
        bit         exp_evt;
        logic [3:0] exp_lvl;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] d, input int c, input int w);
        exp_t e;
        e.dir   = d;
        e.cyc   = c;
        e.width = w;
        sb.push_back(e);
    endtask

    // Output monitor: pops one expectation per dir_valid rise.
    initial begin
        bit   prev_v;
        bit   in_evt;
        exp_t cur;
        int   rise_cyc;
        prev_v   = 1'b0;
        in_evt   = 1'b0;
        rise_cyc = 0;
        cur      = '{dir: 4'b0, cyc: 0, width: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                in_evt = 1'b0;
            end else begin
                if (!dir_valid) chk("dir_zero_when_invalid", 32'(dir), 32'd0);
                else            chk("dir_onehot", 32'($onehot(dir)), 32'd1);
                if (dir_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got dir %b at cycle %0d, required no event", dir, cyc);
                        in_evt = 1'b0;
                    end else begin
                        cur = sb.pop_front();
                        chk("event_dir", 32'(dir), 32'(cur.dir));
                        chk("event_cycle", cyc, cur.cyc);
                        in_evt   = 1'b1;
                        rise_cyc = cyc;
                    end
                end else if (dir_valid && in_evt) begin
                    chk("dir_stable", 32'(dir), 32'(cur.dir));
                end else if (!dir_valid && prev_v && in_evt) begin
                    if (cur.width > 0) chk("valid_width", cyc - rise_cyc, cur.width);
                    in_evt = 1'b0;
                end
                prev_v = dir_valid;
            end
        end
    end

    initial begin
        int         c0;
        logic [3:0] lvl;

        vecs[0] = '{raw: 4'b0100, hold: 12, exp_dir: 4'b0100, exp_evt: 1'b1, exp_lvl: 4'b0100};
        vecs[1] = '{raw: 4'b0001, hold: 3,  exp_dir: 4'b0000, exp_evt: 1'b0, exp_lvl: 4'b0000};
        vecs[2] = '{raw: 4'b1010, hold: 12, exp_dir: 4'b1000, exp_evt: 1'b1, exp_lvl: 4'b1010};
        vecs[3] = '{raw: 4'b1000, hold: 10, exp_dir: 4'b1000, exp_evt: 1'b1, exp_lvl: 4'b1000};
        vecs[4] = '{raw: 4'b0010, hold: 10, exp_dir: 4'b0010, exp_evt: 1'b1, exp_lvl: 4'b0010};
        vecs[5] = '{raw: 4'b0001, hold: 10, exp_dir: 4'b0001, exp_evt: 1'b1, exp_lvl: 4'b0001};
        vecs[6] = '{raw: 4'b1111, hold: 10, exp_dir: 4'b1000, exp_evt: 1'b1, exp_lvl: 4'b1111};
        vecs[7] = '{raw: 4'b0011, hold: 10, exp_dir: 4'b0010, exp_evt: 1'b1, exp_lvl: 4'b0011};
        vecs[8] = '{raw: 4'b0110, hold: 10, exp_dir: 4'b0100, exp_evt: 1'b1, exp_lvl: 4'b0110};
        vecs[9] = '{raw: 4'b0001, hold: 4,  exp_dir: 4'b0001, exp_evt: 1'b1, exp_lvl: 4'b0001};

        rst       = 1'b1;
        btn_raw   = 4'b0000;
        dir_ready = 1'b1;
        step(3);
        chk("reset_valid", 32'(dir_valid), 32'd0);
        chk("reset_dir",   32'(dir),       32'd0);
        chk("reset_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        step(2);

        for (int i = 0; i < 10; i++) begin
            c0      = cyc;
            btn_raw = vecs[i].raw;
            if (vecs[i].exp_evt) push(vecs[i].exp_dir, c0 + LAT, 1);
            lvl = 4'b0000;
            repeat (vecs[i].hold) begin
                step(1);
                lvl |= btn_level;
            end
            btn_raw = 4'b0000;
            repeat (14) begin
                step(1);
                lvl |= btn_level;
            end
            chk("level_seen", 32'(lvl), 32'(vecs[i].exp_lvl));
        end

        // Long hold with ready: single event, or repeats every REP+1 cycles.
        c0 = cyc;
`ifdef BUTTON_AUTOREPEAT_EN
        btn_raw = 4'b0010;
        push(4'b0010, c0 + LAT, 1);
        push(4'b0010, c0 + LAT + REP + 1, 1);
        push(4'b0010, c0 + LAT + 2 * (REP + 1), 1);
`else
        btn_raw = 4'b0100;
        push(4'b0100, c0 + LAT, 1);
`endif
        step(40);
        btn_raw = 4'b0000;
        step(14);

        // Stalled consumer: event must persist past the release.
        dir_ready = 1'b0;
        c0        = cyc;
        btn_raw   = 4'b0001;
        push(4'b0001, c0 + LAT, 30 + 1 - LAT);
        step(20);
        btn_raw = 4'b0000;
        step(10);
        chk("stall_valid", 32'(dir_valid), 32'd1);
        chk("stall_dir",   32'(dir),       32'd1);
        chk("stall_level", 32'(btn_level), 32'd0);
        dir_ready = 1'b1;
        step(14);

        // Reset while an event is pending.
        dir_ready = 1'b0;
        c0        = cyc;
        btn_raw   = 4'b0100;
        push(4'b0100, c0 + LAT, 0);
        step(10);
        rst = 1'b1;
        #1;
        chk("rst_hold_valid", 32'(dir_valid), 32'd0);
        chk("rst_hold_dir",   32'(dir),       32'd0);
        chk("rst_hold_level", 32'(btn_level), 32'd0);
        btn_raw = 4'b0000;
        step(2);
        rst       = 1'b0;
        dir_ready = 1'b1;
        step(20);

        // Button held through reset produces an event once debounced.
        btn_raw = 4'b1000;
        rst     = 1'b1;
        step(3);
        rst = 1'b0;
        c0  = cyc;
        push(4'b1000, c0 + LAT, 1);
        step(12);
        btn_raw = 4'b0000;
        step(14);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
